apb_m_ctrl: RTL and testbench



---
 rtl/apb_m_ctrl.sv | 158 +++++++++++++++
 tb/tb_apb_m_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_m_ctrl.sv
// APB3 master: turns a valid/ready command stream into SETUP/ACCESS transfers, one response each.
// Optional wait-state timeout abort is built only when APB_M_TIMEOUT_EN is defined.
module apb_m_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_M_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            rsp_tout_q, rsp_tout_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_M_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_tout_d  = rsp_tout_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StSetup;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
`ifdef APB_M_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      StAccess: begin
        if (pready) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
`ifdef APB_M_TIMEOUT_EN
          rsp_tout_d  = 1'b0;
        end else if (wait_cnt_q == CntW'(TIMEOUT_CYC)) begin
          // Slave stalled too long: abort without data.
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_M_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_tout_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_M_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_tout_q  <= rsp_tout_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_M_TIMEOUT_EN
  assign rsp_tout  = rsp_tout_q;
`else
  assign rsp_tout  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_m_ctrl.sv
// Directed bench for apb_m_ctrl: expected responses are queued at each handshake and
// matched against rsp_* pulses; APB pin timing is counted per transfer.
module tb_apb_m_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TC = 16;

  logic          pclk, presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_tout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  apb_m_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TC)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tout(rsp_tout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int unsigned last_hs = 0;
  int unsigned prev_hs = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tout;
    int unsigned   hs;
    int unsigned   lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  exp_t got;
  always @(negedge pclk) begin
    if (presetn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(got.err));
        chk("rsp_tout", 32'(rsp_tout), 32'(got.tout));
        chk("rsp_latency", cyc - got.hs, got.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input exp_t e_in);
    exp_t e;
    int n;
    e = e_in;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    e.hs = cyc + 1;
    exp_q.push_back(e);
    prev_hs = last_hs;
    last_hs = e.hs;
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
  endtask

  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] prd, input logic serr,
                         input logic tmo);
    exp_t e;
    int ps, pe, acc, n;
    e.rdata = (wr || tmo) ? '0 : prd;
    e.err   = serr | tmo;
    e.tout  = tmo;
    e.hs    = 0;
    e.lat   = tmo ? 2 + TC : 2 + waits;
    issue(wr, a, d, e);
    ps = 0; pe = 0; acc = 0; n = 0;
    while (psel && n < 100) begin
      ps++;
      chk("paddr_hold", 32'(paddr), 32'(a));
      chk("pwrite_hold", 32'(pwrite), 32'(wr));
      chk("pwdata_hold", 32'(pwdata), 32'(d));
      if (penable) begin
        pe++;
        pready  = !tmo && (acc >= waits);
        prdata  = pready ? prd : DW'($urandom);
        pslverr = pready ? serr : 1'($urandom);
        acc++;
      end else begin
        pready = 1'b0;
      end
      @(negedge pclk);
      n++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("psel_cycles", ps, tmo ? TC + 2 : 2 + waits);
    chk("penable_cycles", pe, tmo ? TC + 1 : 1 + waits);
    chk("penable_low_after", 32'(penable), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    int stuck;
    presetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_paddr", 32'(paddr), 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    do_xfer(1'b1, 4'h1, 8'hAA, 0, 8'h00, 1'b0, 1'b0);    // write, no waits
    do_xfer(1'b0, 4'h1, 8'h11, 0, 8'hAA, 1'b0, 1'b0);    // read
    do_xfer(1'b1, 4'hA, 8'h55, 0, 8'h00, 1'b1, 1'b0);    // slave error
    do_xfer(1'b1, 4'h5, 8'h0F, 0, 8'h00, 1'b0, 1'b0);
    chk("accept_gap", last_hs - prev_hs, 32'd3);
    do_xfer(1'b0, 4'h3, 8'h00, 3, 8'hCC, 1'b0, 1'b0);    // three wait states
    do_xfer(1'b0, 4'hE, 8'h7E, 1, 8'h96, 1'b1, 1'b0);    // read error after one wait
`ifdef APB_M_TIMEOUT_EN
    do_xfer(1'b0, 4'h9, 8'h00, 0, 8'h5A, 1'b0, 1'b1);    // pready stuck: abort
    stuck = 4;
`else
    stuck = 30;
`endif

    // Stall a read, then reset in the middle of ACCESS.
    e.rdata = '0; e.err = 1'b0; e.tout = 1'b0; e.hs = 0; e.lat = 0;
    issue(1'b0, 4'h7, 8'h00, e);
    pready = 1'b0;
    for (int i = 0; i < stuck; i++) @(negedge pclk);
    chk("stall_psel", 32'(psel), 32'd1);
    chk("stall_penable", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_xfer(1'b1, 4'h2, 8'h3C, 0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge pclk);
    chk("rsp_pending", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
